// File: rtl/phy_rx_link_ctrl.sv
// -----------------------------------------------------------------------------
// phy_rx_link_ctrl
//   Link-level sequencer for the phy_rx deserializer (byte-clock domain).
//   Holds the deserializer in re-init, waits for comma lock (deser_active),
//   qualifies the byte stream toward the upper layer, detects loss of
//   alignment and re-initialises automatically.
//
// Parameters
//   INIT_CYCLES   cycles deser_default_values stays high per init attempt
//   SYNC_TIMEOUT  cycles allowed in WAIT_SYNC before re-init
//   LOSS_LIMIT    consecutive bad byte slots in LINK_UP that declare loss
//
// Ports
//   clk_4f               in   byte clock
//   default_values       in   asynchronous active-high reset
//   rx_enable            in   1 = bring up / keep link, 0 = park deserializer
//   deser_active         in   deserializer comma lock
//   deser_valid          in   deserializer data byte present
//   deser_data[7:0]      in   deserializer data byte
//   deser_default_values out  re-init strobe to deserializer
//   link_up              out  link synchronised
//   valid_out            out  qualified byte valid
//   data_out[7:0]        out  qualified byte
//   sync_timeout         out  one-cycle pulse on WAIT_SYNC timeout
//   resync_count[7:0]    out  saturating LOST/timeout count
//                             (only when PHY_RX_LINK_STATS_EN is defined)
// -----------------------------------------------------------------------------
module phy_rx_link_ctrl #(
   parameter int unsigned INIT_CYCLES  = 4,
   parameter int unsigned SYNC_TIMEOUT = 64,
   parameter int unsigned LOSS_LIMIT   = 4
) (
   input  logic       clk_4f,
   input  logic       default_values,
   input  logic       rx_enable,
   input  logic       deser_active,
   input  logic       deser_valid,
   input  logic [7:0] deser_data,
   output logic       deser_default_values,
   output logic       link_up,
   output logic       valid_out,
   output logic [7:0] data_out,
   output logic       sync_timeout
`ifdef PHY_RX_LINK_STATS_EN
   ,
   output logic [7:0] resync_count
`endif
);

   localparam int unsigned CW_I = (INIT_CYCLES  > 1) ? $clog2(INIT_CYCLES)  : 1;
   localparam int unsigned CW_S = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
   localparam int unsigned CW   = (CW_I > CW_S) ? CW_I : CW_S;
   localparam int unsigned BW   = (LOSS_LIMIT   > 1) ? $clog2(LOSS_LIMIT)   : 1;

   localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
   localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_TIMEOUT - 1);
   localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_LIMIT - 1);
   localparam logic [7:0]    COMMA     = 8'hBC;

   typedef enum logic [2:0] {
      DISABLED,
      INIT,
      WAIT_SYNC,
      LINK_UP,
      LOST
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [BW-1:0]   bad_q;
   logic            dv_q;
   logic            link_up_q;
   logic            valid_q;
   logic [7:0]      data_q;
   logic            timeout_q;
`ifdef PHY_RX_LINK_STATS_EN
   logic [7:0]      stats_q;
`endif

   logic slot_bad;
   logic loss;

   // Idle commas count as good slots even without deser_valid.
   assign slot_bad = !deser_valid && (deser_data != COMMA);
   // Loss fires on the LOSS_LIMIT-th consecutive bad slot, so bad_q never
   // has to hold LOSS_LIMIT itself.
   assign loss     = !deser_active || (slot_bad && (bad_q == LOSS_LAST));

   always_ff @(posedge clk_4f or posedge default_values) begin
      if (default_values) begin
         state_q   <= DISABLED;
         cnt_q     <= '0;
         bad_q     <= '0;
         dv_q      <= 1'b1;
         link_up_q <= 1'b0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         timeout_q <= 1'b0;
`ifdef PHY_RX_LINK_STATS_EN
         stats_q   <= '0;
`endif
      end else begin
         // link_up/valid_out are only raised while staying in LINK_UP, so
         // both drop together on the edge that leaves it.
         timeout_q <= 1'b0;
         link_up_q <= 1'b0;
         valid_q   <= 1'b0;
         dv_q      <= 1'b0;
         if (!rx_enable) begin
            // Overrides any timeout or loss seen in the same cycle.
            state_q <= DISABLED;
            cnt_q   <= '0;
            bad_q   <= '0;
            dv_q    <= 1'b1;
         end else begin
            case (state_q)
               DISABLED: begin
                  state_q <= INIT;
                  cnt_q   <= '0;
                  dv_q    <= 1'b1;
               end
               INIT: begin
                  if (cnt_q == INIT_LAST) begin
                     state_q <= WAIT_SYNC;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                     dv_q  <= 1'b1;
                  end
               end
               WAIT_SYNC: begin
                  if (deser_active) begin
                     state_q <= LINK_UP;
                     cnt_q   <= '0;
                     bad_q   <= '0;
                  end else if (cnt_q == SYNC_LAST) begin
                     state_q   <= INIT;
                     cnt_q     <= '0;
                     dv_q      <= 1'b1;
                     timeout_q <= 1'b1;
`ifdef PHY_RX_LINK_STATS_EN
                     if (stats_q != 8'hFF) stats_q <= stats_q + 8'd1;
`endif
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               LINK_UP: begin
                  if (loss) begin
                     state_q <= LOST;
                     cnt_q   <= '0;
                     bad_q   <= '0;
`ifdef PHY_RX_LINK_STATS_EN
                     if (stats_q != 8'hFF) stats_q <= stats_q + 8'd1;
`endif
                  end else begin
                     link_up_q <= 1'b1;
                     valid_q   <= deser_valid;
                     if (deser_valid) data_q <= deser_data;
                     bad_q <= slot_bad ? bad_q + BW'(1) : '0;
                  end
               end
               LOST: begin
                  state_q <= INIT;
                  cnt_q   <= '0;
                  dv_q    <= 1'b1;
               end
               default: begin
                  state_q <= DISABLED;
                  cnt_q   <= '0;
                  bad_q   <= '0;
                  dv_q    <= 1'b1;
               end
            endcase
         end
      end
   end

   assign deser_default_values = dv_q;
   assign link_up              = link_up_q;
   assign valid_out            = valid_q;
   assign data_out             = data_q;
   assign sync_timeout         = timeout_q;
`ifdef PHY_RX_LINK_STATS_EN
   assign resync_count         = stats_q;
`endif

endmodule

// File: doc/phy_rx_link_ctrl.md
Name: phy_rx_link_ctrl

Overview:
- Link-level sequencer for the phy_rx serial-to-parallel deserializer.
- Drives the deserializer's default_values (re-init) input and waits for it to report comma (8'hBC) lock via active.
- Qualifies its byte stream toward the upper layer, detects loss of alignment, and re-initialises and resynchronises automatically.
- Runs in the byte-clock domain (clk_4f); deserializer outputs are registered and stable for one full clk_4f period.

Parameters:
- INIT_CYCLES, 4, clk_4f cycles deser_default_values is held high per init attempt (>=1)
- SYNC_TIMEOUT, 64, clk_4f cycles allowed in WAIT_SYNC before re-init (>=2)
- LOSS_LIMIT, 4, consecutive bad byte slots in LINK_UP that declare loss of sync (>=1)

Ports:
- clk_4f  input  1  byte clock
- default_values  input  1  asynchronous, active-high reset
- rx_enable  input  1  1 = bring up/keep link; 0 = park deserializer in reset
- deser_active  input  1  active from deserializer (>=4 commas seen)
- deser_valid  input  1  valid from deserializer (data byte present)
- deser_data  input  8  data_out from deserializer
- deser_default_values  output  1  re-init strobe to deserializer
- link_up  output  1  link synchronised
- valid_out  output  1  qualified data byte valid
- data_out  output  8  qualified data byte
- sync_timeout  output  1  one-cycle pulse when WAIT_SYNC times out

Behaviour:
- Reset values: state = DISABLED, deser_default_values = 1, link_up = 0, valid_out = 0, data_out = 8'h00, sync_timeout = 0, all counters = 0.
- All outputs are registered. Latency deser_data/deser_valid -> data_out/valid_out is 1 clk_4f cycle.
- States and transitions:
  - DISABLED: deser_default_values = 1. If rx_enable = 1, go to INIT with cnt = 0.
  - INIT: deser_default_values = 1; cnt++. When cnt == INIT_CYCLES-1, go to WAIT_SYNC with cnt = 0.
  - WAIT_SYNC: deser_default_values = 0. If deser_active = 1, go to LINK_UP. Otherwise cnt++; when cnt == SYNC_TIMEOUT-1, pulse sync_timeout for one cycle and go to INIT with cnt = 0.
  - LINK_UP: link_up = 1.
    - Pass-through: valid_out <= deser_valid. data_out <= deser_data only when deser_valid = 1; otherwise data_out holds.
    - A byte slot is good if deser_valid = 1 or deser_data == 8'hBC; otherwise it is bad.
    - bad_cnt increments on a bad slot and clears on a good slot.
    - If bad_cnt reaches LOSS_LIMIT, or deser_active = 0, go to LOST.
  - LOST: a single cycle. link_up = 0, valid_out = 0, then go to INIT with cnt = 0.
- link_up and valid_out are 0 in every state except LINK_UP. On leaving LINK_UP, valid_out drops in the same cycle link_up drops.
- Priority: rx_enable = 0 forces DISABLED on the next edge from any state. It overrides a timeout or loss detected in the same cycle, and in that case no sync_timeout pulse is issued.
- A loss trigger and a good byte in the same cycle resolve to LOST when deser_active = 0.
- Bytes present in the cycle that triggers LOST are not forwarded.
- Counters use $clog2 widths of their limits and never wrap within a state: each clears on every state entry.
- Reset asserted mid-operation returns all outputs to reset values immediately (asynchronous), not at the next edge.

Optional Feature:
- Macro: PHY_RX_LINK_STATS_EN.
- Defined:
  - Adds output resync_count [7:0].
  - Increments on every LOST entry and every sync_timeout pulse, saturating at 8'hFF.
  - Clears only on default_values; holds through DISABLED.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release with rx_enable = 1 and deser_active rising 5 cycles after INIT exit -> deser_default_values high exactly 4 cycles, then low; link_up = 1 two edges after deser_active = 1.
- LINK_UP, deser_valid = 1 with bytes 8'h11, 8'h22, 8'h33 -> data_out shows 8'h11, 8'h22, 8'h33 one cycle later with valid_out = 1. An interleaved 8'hBC with deser_valid = 0 -> valid_out = 0 and data_out holds 8'h22.
- LINK_UP, 4 consecutive slots of deser_valid = 0 and deser_data = 8'h5A -> LOST after the 4th, link_up = 0, deser_default_values re-asserted for 4 cycles. With 3 bad slots then 8'hBC, the link stays up.
- deser_active held 0 -> sync_timeout pulses every 64 + 4 cycles; with PHY_RX_LINK_STATS_EN, resync_count increments per pulse and saturates at 255 after 255 timeouts.
- rx_enable dropped in LINK_UP on the same cycle as the 4th bad slot -> DISABLED, no LOST, no resync_count increment, deser_default_values = 1 held.
- default_values pulsed asynchronously mid-LINK_UP between clock edges -> link_up, valid_out = 0 and data_out = 8'h00 immediately; re-sync on release.
